// File: rtl/csa_accum_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator slice.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_EXT   = 4;
  localparam int DEF_CW    = 8;

  // Accumulator width: operand width plus guard bits for the group size.
  function automatic int calc_ow(input int width, input int ext);
    return width + ext;
  endfunction

endpackage

// File: rtl/csa_compress.sv
// One row of per-bit compressors: 3:2 full-add (mode 0) or half-add (mode 1).
// Each bit is kept as a separate XOR/majority so the mapper sees FA/HA cells.
module csa_compress #(
  parameter int OW = 20
) (
  input  logic          mode,
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic [OW-1:0] x,
  output logic [OW-1:0] sum,
  output logic [OW-1:0] carry
);

  logic [OW-1:0] maj;

  genvar i;
  generate
    for (i = 0; i < OW; i++) begin : g_bit
      // Per-bit sum and carry-generate; in half-add mode the third input is ignored.
      always_comb begin
        if (mode) begin
          sum[i] = a[i] ^ b[i];
          maj[i] = a[i] & b[i];
        end else begin
          sum[i] = a[i] ^ b[i] ^ x[i];
          maj[i] = (a[i] & b[i]) | (a[i] & x[i]) | (b[i] & x[i]);
        end
      end

      // Carries move up one weight; the MSB carry-out falls off (modulo 2^OW).
      if (i == 0) begin : g_lsb
        assign carry[i] = 1'b0;
      end else begin : g_upper
        assign carry[i] = maj[i-1];
      end
    end
  endgenerate

endmodule

// File: rtl/csa_accum_ctrl.sv
// Streaming N-operand accumulator: folds operands into a carry-save pair,
// then resolves the pair with repeated half-add steps before presenting the sum.
module csa_accum_ctrl
  import csa_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXT   = DEF_EXT,
  parameter int CW    = DEF_CW,
  localparam int OW   = calc_ow(WIDTH, EXT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_sum,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  state_t state, next_state;

  logic [OW-1:0] s_reg, c_reg;
  logic [CW-1:0] cnt;

  logic [OW-1:0] x_ext;
  logic [OW-1:0] row_sum, row_carry;
  logic          accept, step, clear;

  assign x_ext = {{EXT{1'b0}}, in_data};

  // The same compressor row serves both phases; RESOLVE switches it to half-add.
  csa_compress #(.OW(OW)) u_row (
    .mode  (state == RESOLVE),
    .a     (s_reg),
    .b     (c_reg),
    .x     (x_ext),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // Next-state, handshake and datapath-enable decoding.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = in_last ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        if (c_reg == '0) begin
          next_state = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, carry-save pair and saturating operand counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (clear) begin
        s_reg <= '0;
        c_reg <= '0;
        cnt   <= '0;
      end else begin
        if (accept || step) begin
          s_reg <= row_sum;
          c_reg <= row_carry;
        end
        if (accept && (cnt != {CW{1'b1}})) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign out_sum   = s_reg;
  assign out_count = cnt;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed, table-driven bench for csa_accum_ctrl with hand-computed sums.
module tb_csa_accum_ctrl;

  localparam int WIDTH = 16;
  localparam int EXT   = 4;
  localparam int CW    = 8;
  localparam int OW    = WIDTH + EXT;
  localparam int WAIT_LIMIT = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OW-1:0]    out_sum;
  logic [CW-1:0]    out_count;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Operand i of a group is first + i*step (truncated to WIDTH bits).
  typedef struct {
    string       name;
    int          n;
    logic [15:0] first;
    logic [15:0] step;
    logic [19:0] exp_sum;
    logic [7:0]  exp_count;
    int          exp_lat;
  } vec_t;

  vec_t tbl[7];

  csa_accum_ctrl #(.WIDTH(WIDTH), .EXT(EXT), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one group back-to-back; reports whether in_ready stayed high.
  task automatic applyStimulus(input vec_t v, output logic all_ready);
    all_ready = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_data  = v.first + 16'(i) * v.step;
      in_last  = (i == v.n - 1);
      if (in_ready !== 1'b1) all_ready = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Counts edges from the last-accept edge until out_valid, bounded.
  task automatic waitDone(input string name, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < WAIT_LIMIT) begin
      tick();
      lat++;
    end
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, "_hs_valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, "_hs_busy"},  32'(busy),      32'd0);
    checkOutput({name, "_hs_ready"}, 32'(in_ready),  32'd1);
    checkOutput({name, "_hs_sum"},   32'(out_sum),   32'd0);
    checkOutput({name, "_hs_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    logic all_ready;
    int   lat;
    vec_t v;

    tbl[0] = '{"single5",  1,   16'h0005, 16'h0000, 20'h00005, 8'd1,   2};
    tbl[1] = '{"seq357",   3,   16'h0003, 16'h0002, 20'h0000F, 8'd3,   0};
    tbl[2] = '{"ones16",   16,  16'hFFFF, 16'h0000, 20'hFFFF0, 8'd16,  0};
    tbl[3] = '{"ones17",   17,  16'hFFFF, 16'h0000, 20'h0FFEF, 8'd17,  0};
    tbl[4] = '{"nocarry",  2,   16'h0001, 16'h0001, 20'h00003, 8'd2,   2};
    tbl[5] = '{"sat300",   300, 16'h0001, 16'h0000, 20'h0012C, 8'd255, 0};
    tbl[6] = '{"zero",     1,   16'h0000, 16'h0000, 20'h00000, 8'd1,   2};

    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", 32'(in_ready),  32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum",   32'(out_sum),   32'd0);
    checkOutput("rst_count", 32'(out_count), 32'd0);
    checkOutput("rst_busy",  32'(busy),      32'd0);

    // Main table: stream, wait for result, check, then release it.
    for (int t = 0; t < 7; t++) begin
      v = tbl[t];
      applyStimulus(v, all_ready);
      checkOutput({v.name, "_inready"}, 32'(all_ready), 32'd1);
      waitDone(v.name, lat);
      checkOutput({v.name, "_sum"},   32'(out_sum),   32'(v.exp_sum));
      checkOutput({v.name, "_count"}, 32'(out_count), 32'(v.exp_count));
      checkOutput({v.name, "_busy"},  32'(busy),      32'd1);
      checkOutput({v.name, "_nordy"}, 32'(in_ready),  32'd0);
      if (v.exp_lat != 0)
        checkOutput({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
      else
        checkOutput({v.name, "_latbound"}, 32'(lat >= 2 && lat <= OW + 2), 32'd1);
      handshake(v.name);
    end

    // Back-pressure: result must hold and new operands must be refused.
    applyStimulus(tbl[1], all_ready);
    waitDone("bp", lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'hAAAA;
      in_last  = 1'b1;
      tick();
      checkOutput($sformatf("bp_sum%0d", i),   32'(out_sum),   32'd15);
      checkOutput($sformatf("bp_count%0d", i), 32'(out_count), 32'd3);
      checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_ready%0d", i), 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    handshake("bp");
    tick();
    checkOutput("bp_idle_sum", 32'(out_sum), 32'd0);

    // Reset in the middle of a group discards it.
    v = '{"pre_rst", 2, 16'h0001, 16'h0001, 20'h00003, 8'd2, 0};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i + 1);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput("mid_busy", 32'(busy),    32'd1);
    checkOutput("mid_sum",  32'(out_sum), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_ready", 32'(in_ready),  32'd1);
    checkOutput("mrst_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_sum",   32'(out_sum),   32'd0);
    checkOutput("mrst_count", 32'(out_count), 32'd0);
    checkOutput("mrst_busy",  32'(busy),      32'd0);
    v = '{"post_rst", 2, 16'h0001, 16'h0000, 20'h00002, 8'd2, 0};
    applyStimulus(v, all_ready);
    waitDone(v.name, lat);
    checkOutput("post_rst_sum",   32'(out_sum),   32'd2);
    checkOutput("post_rst_count", 32'(out_count), 32'd2);
    handshake(v.name);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequenced multi-operand accumulator built on the Nangate45 full/half-adder cells. Operands stream in over a valid/ready handshake and are folded into a registered carry-save pair by one row of 3:2 compressors, which synthesis maps to `FA_X1`. On the last operand, the same storage is resolved by repeated half-add steps, which map to `HA_X1`. The block is the scheduler that sits in front of the `$fa` datapath in arithmetic blocks that need N-operand sums without a wide carry-propagate adder.

## Interface
Parameters:
- `WIDTH`, 16: operand width.
- `EXT`, 4: guard bits; the accumulator width is `OW = WIDTH+EXT`.
- `CW`, 8: operand-counter width.

Ports:
- `clk`  in  1  clock; the block uses this single clock only.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand accepted this cycle when high together with `in_valid`.
- `in_data`  in  WIDTH  unsigned operand.
- `in_last`  in  1  marks the final operand of a group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  OW  sum of the group, modulo 2^OW.
- `out_count`  out  CW  operands accepted in the group; saturates at 2^CW-1.
- `busy`  out  1  state is not IDLE.

## Operation
Registers:
- `S` and `C`: OW-bit carry-save pair.
- `cnt`: CW-bit operand counter.
- `state`: one of IDLE, ACCUM, RESOLVE, DONE.

Transfers:
- An operand is accepted when `in_valid & in_ready`.
- On accept: `S <= S^C^X` and `C <= maj(S,C,X)<<1`, where `X` is `in_data` zero-extended to OW. `cnt` increments unless already saturated.

State transitions:
- IDLE: `in_ready=1`. Accept without `in_last` goes to ACCUM. Accept with `in_last` goes to RESOLVE.
- ACCUM: `in_ready=1`. Accept with `in_last` goes to RESOLVE. Idle cycles hold all state.
- RESOLVE: `in_ready=0`.
  - If `C==0`, go to DONE with `S` and `C` unchanged.
  - Otherwise perform one half-add step, `S <= S^C` and `C <= (S&C)<<1`; the bit shifted out of the MSB is dropped (modulo).
  - At most OW steps occur before `C==0`.
- DONE: `out_valid=1` and `out_sum=S`. It holds until `out_ready`. On handshake, clear `S`, `C` and `cnt`, then go to IDLE.

Rules:
- All arithmetic is modulo 2^OW. There is no overflow flag; callers size `EXT` as ≥ ceil(log2(max operands)) for an exact result.
- `in_ready` is 0 in RESOLVE and DONE; `in_valid` is ignored there.
- `out_sum` and `out_count` show register contents at all times, but are meaningful only while `out_valid=1`.

## Timing
- Reset: `state=IDLE`; `S`, `C` and `cnt` are 0. Outputs after reset: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, `busy=0`.
- Reset mid-operation: `rst` has priority over every transfer and returns all registers to their reset values at that edge; any in-flight group is lost.
- Accept throughput: one operand per cycle with no bubbles.
- Latency: when the last operand is accepted at edge t, `out_valid` rises after edge t+1+k, where k is the number of half-add steps needed (0 ≤ k ≤ OW).
  - A single-operand group, or any group that leaves `C==0`, therefore takes 2 edges.
- Back-pressure: `out_sum` and `out_count` stay stable while `out_valid & !out_ready`.
- After the output handshake at edge u, `in_ready=1` from u onward. There is no same-cycle accept in DONE.

## Structure
- Package `csa_accum_pkg` holds the `state_t` enum (IDLE, ACCUM, RESOLVE, DONE) and a localparam helper for OW.
- Sub-module `csa_compress` is a purely combinational OW-bit row that computes either the 3:2 compression (mode 0) or the half-add step (mode 1). It is written as per-bit XOR/majority so techmap infers `FA_X1` and `HA_X1`.
- The controller holds the FSM, the registers and the handshake logic.

## Test plan
- Single operand 0x0005 with `in_last`: `out_sum=0x00005`, `out_count=1`, `out_valid` after accept edge +2.
- Operands 3, 5, 7 back-to-back, last on 7: `out_sum=15`, `out_count=3`, `in_ready` held high through all three accepts.
- Sixteen operands of 0xFFFF: `out_sum=0xFFFF0` exactly; the RESOLVE step count is ≤ 20.
- Seventeen operands of 0xFFFF: `out_sum=0x0FFEF` (wrap modulo 2^20), `out_count=17`.
- `out_ready` held low for 5 cycles in DONE: `out_sum` and `out_count` stable, `in_ready=0`, `in_valid` pulses ignored; the handshake then returns the block to IDLE with `busy=0`.
- `rst` pulsed after 2 operands in ACCUM: next cycle all outputs are at reset values; a new group 1, 1 then yields `out_sum=2`, `out_count=2`.
